// File: rtl/qa_update_ctrl_if.sv
// Request, Q-table BRAM and QA datapath signals of the Q-learning update controller.
// The slave modport is the controller's view; master is the surrounding system's view.
interface qa_update_ctrl_if #(
  parameter int S_WIDTH = 8,
  parameter int L_WIDTH = 4,
  parameter int Q_WIDTH = 16,
  parameter int R_WIDTH = 16
);
  logic                                 req_valid;
  logic                                 req_ready;
  logic [S_WIDTH-1:0]                   req_S;
  logic [S_WIDTH-1:0]                   req_S_next;
  logic [2+L_WIDTH/2-1:0]               req_A;
  logic [R_WIDTH-1:0]                   req_R;
  logic                                 bram_rd_en;
  logic [S_WIDTH-1:0]                   bram_rd_addr;
  logic [3:0]                           bram_wr_en;
  logic [2**(L_WIDTH/2)-1:0]            bram_wr_lane;
  logic [S_WIDTH-1:0]                   bram_wr_addr;
  logic [Q_WIDTH*(2**(L_WIDTH/2))-1:0]  bram_wr_data;
  logic [2+L_WIDTH/2-1:0]               qa_A;
  logic [R_WIDTH-1:0]                   qa_R;
  logic [Q_WIDTH-1:0]                   qa_Q_new;
  logic                                 done;
  logic [31:0]                          step_cnt;

  modport slave (
    input  req_valid, req_S, req_S_next, req_A, req_R, qa_Q_new,
    output req_ready, bram_rd_en, bram_rd_addr, bram_wr_en, bram_wr_lane,
           bram_wr_addr, bram_wr_data, qa_A, qa_R, done, step_cnt
  );

  modport master (
    output req_valid, req_S, req_S_next, req_A, req_R, qa_Q_new,
    input  req_ready, bram_rd_en, bram_rd_addr, bram_wr_en, bram_wr_lane,
           bram_wr_addr, bram_wr_data, qa_A, qa_R, done, step_cnt
  );
endinterface

// File: rtl/qa_update_ctrl.sv
// Sequences one Q-learning update: two Q-table row reads, a fixed wait for the QA
// pipeline, then a single-entry write of Q_new. Only one update is ever in flight.
module qa_update_ctrl #(
  parameter int S_WIDTH = 8,
  parameter int L_WIDTH = 4,
  parameter int Q_WIDTH = 16,
  parameter int R_WIDTH = 16,
  parameter int RD_LAT  = 1,
  parameter int QA_LAT  = 3
) (
  input logic              clk,
  input logic              rst,
  qa_update_ctrl_if.slave  bus
);
  localparam int A_WIDTH  = 2 + L_WIDTH/2;
  localparam int N_LEVEL  = 2**(L_WIDTH/2);
  localparam int PIPE_LEN = RD_LAT + QA_LAT;
  localparam int CNT_W    = $clog2(PIPE_LEN + 1);

  typedef enum logic [2:0] {IDLE, RD_CUR, RD_NEXT, PIPE, WRITE} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          pipe_cnt;
  logic [S_WIDTH-1:0]        s_q, s_next_q, rd_addr_q, wr_addr_q;
  logic [A_WIDTH-1:0]        a_q;
  logic [R_WIDTH-1:0]        r_q;
  logic [Q_WIDTH*N_LEVEL-1:0] wr_data_q;
  logic [Q_WIDTH*N_LEVEL-1:0] q_new_rep;
  logic [31:0]               step_q;
  logic                      accept, pipe_last;
  logic [N_LEVEL-1:0]        lane_one;

  assign accept    = bus.req_valid && (state == IDLE);
  assign pipe_last = (pipe_cnt == CNT_W'(PIPE_LEN - 1));
  assign lane_one  = {{(N_LEVEL-1){1'b0}}, 1'b1};
  assign q_new_rep = {N_LEVEL{bus.qa_Q_new}};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.req_ready    = 1'b0;
    bus.bram_rd_en   = 1'b0;
    bus.bram_wr_en   = 4'b0000;
    bus.bram_wr_lane = '0;
    bus.bram_wr_data = wr_data_q;
    bus.done         = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_nxt = RD_CUR;
      end
      RD_CUR: begin
        bus.bram_rd_en = 1'b1;
        state_nxt      = RD_NEXT;
      end
      RD_NEXT: begin
        bus.bram_rd_en = 1'b1;
        state_nxt      = PIPE;
      end
      PIPE: begin
        if (pipe_last) state_nxt = WRITE;
      end
      WRITE: begin
        // Q_new is taken straight from QA in this cycle and replicated on all lanes.
        bus.bram_wr_en   = 4'b0001 << a_q[1:0];
        bus.bram_wr_lane = lane_one << a_q[A_WIDTH-1:2];
        bus.bram_wr_data = q_new_rep;
        bus.done         = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q       <= '0;
      s_next_q  <= '0;
      a_q       <= '0;
      r_q       <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pipe_cnt  <= '0;
      step_q    <= '0;
    end else begin
      if (accept) begin
        s_q       <= bus.req_S;
        s_next_q  <= bus.req_S_next;
        a_q       <= bus.req_A;
        r_q       <= bus.req_R;
        rd_addr_q <= bus.req_S;
      end
      if (state == RD_CUR)  rd_addr_q <= s_next_q;
      if (state == RD_NEXT) pipe_cnt  <= '0;
      if (state == PIPE) begin
        pipe_cnt <= pipe_cnt + 1'b1;
        if (pipe_last) wr_addr_q <= s_q;
      end
      if (state == WRITE) begin
        wr_data_q <= q_new_rep;
        step_q    <= step_q + 32'd1;
      end
    end
  end

  assign bus.bram_rd_addr = rd_addr_q;
  assign bus.bram_wr_addr = wr_addr_q;
  assign bus.qa_A         = a_q;
  assign bus.qa_R         = r_q;
  assign bus.step_cnt     = step_q;

endmodule

// File: tb/tb_qa_update_ctrl.sv
// Directed bench for qa_update_ctrl: default latencies on dut0, RD_LAT=3/QA_LAT=7 on dut1.
module tb_qa_update_ctrl;
  localparam int P0 = 4;
  localparam int P1 = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  qa_update_ctrl_if #(.S_WIDTH(8), .L_WIDTH(4), .Q_WIDTH(16), .R_WIDTH(16)) bus0 ();
  qa_update_ctrl_if #(.S_WIDTH(8), .L_WIDTH(4), .Q_WIDTH(16), .R_WIDTH(16)) bus1 ();

  qa_update_ctrl #(.S_WIDTH(8), .L_WIDTH(4), .Q_WIDTH(16), .R_WIDTH(16),
                   .RD_LAT(1), .QA_LAT(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  qa_update_ctrl #(.S_WIDTH(8), .L_WIDTH(4), .Q_WIDTH(16), .R_WIDTH(16),
                   .RD_LAT(3), .QA_LAT(7)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] s, input logic [7:0] sn,
                               input logic [3:0] a, input logic [15:0] r);
    bus0.req_valid  = v;
    bus0.req_S      = s;
    bus0.req_S_next = sn;
    bus0.req_A      = a;
    bus0.req_R      = r;
  endtask

  task automatic waitReady(input string tag);
    int guard = 0;
    while (!bus0.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput(tag, 64'(guard < 50), 64'd1);
  endtask

  // Fields are scrambled every cycle after the accept to show only latched values are used.
  task automatic runSingle(input logic [7:0] s, input logic [7:0] sn, input logic [3:0] a,
                           input logic [15:0] r, input logic [15:0] q, input int exp_step);
    logic [3:0] exp_wr;
    logic [3:0] exp_lane;
    exp_wr   = 4'b0001 << a[1:0];
    exp_lane = 4'b0001 << a[3:2];
    @(negedge clk);
    applyStimulus(1'b1, s, sn, a, r);
    bus0.qa_Q_new = q;
    waitReady("single_accept_wait");
    for (int j = 0; j <= P0 + 3; j++) begin
      @(negedge clk);
      applyStimulus(1'b0, 8'($urandom), 8'($urandom), 4'($urandom), 16'($urandom));
      if (j == 0) begin
        checkOutput("rd_cur_en", 64'(bus0.bram_rd_en), 64'd1);
        checkOutput("rd_cur_addr", 64'(bus0.bram_rd_addr), 64'(s));
      end else if (j == 1) begin
        checkOutput("rd_next_en", 64'(bus0.bram_rd_en), 64'd1);
        checkOutput("rd_next_addr", 64'(bus0.bram_rd_addr), 64'(sn));
      end else if (j < P0 + 2) begin
        checkOutput("pipe_quiet", {59'd0, bus0.bram_rd_en, bus0.bram_wr_en}, 64'd0);
      end else if (j == P0 + 2) begin
        checkOutput("wr_en", 64'(bus0.bram_wr_en), 64'(exp_wr));
        checkOutput("wr_lane", 64'(bus0.bram_wr_lane), 64'(exp_lane));
        checkOutput("wr_addr", 64'(bus0.bram_wr_addr), 64'(s));
        checkOutput("wr_data", bus0.bram_wr_data, {q, q, q, q});
        checkOutput("done", 64'(bus0.done), 64'd1);
        checkOutput("qa_A", 64'(bus0.qa_A), 64'(a));
        checkOutput("qa_R", 64'(bus0.qa_R), 64'(r));
      end else begin
        checkOutput("post_ready", 64'(bus0.req_ready), 64'd1);
        checkOutput("post_wr_en", 64'(bus0.bram_wr_en), 64'd0);
        checkOutput("step_cnt", 64'(bus0.step_cnt), 64'(exp_step));
      end
    end
  endtask

  initial begin
    logic [7:0]  bs [3];
    logic [7:0]  bsn[3];
    logic [3:0]  ba [3];
    logic [15:0] br [3];
    int          acc_t[3];
    int          n_acc;
    int          n_wr;
    int          j;
    logic        pend;

    applyStimulus(1'b0, 8'd0, 8'd0, 4'd0, 16'd0);
    bus0.qa_Q_new   = 16'd0;
    bus1.req_valid  = 1'b0;
    bus1.req_S      = 8'd0;
    bus1.req_S_next = 8'd0;
    bus1.req_A      = 4'd0;
    bus1.req_R      = 16'd0;
    bus1.qa_Q_new   = 16'h7777;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_ready", 64'(bus0.req_ready), 64'd1);
    checkOutput("rst_rd_en", 64'(bus0.bram_rd_en), 64'd0);
    checkOutput("rst_wr_en", 64'(bus0.bram_wr_en), 64'd0);
    checkOutput("rst_lane", 64'(bus0.bram_wr_lane), 64'd0);
    checkOutput("rst_addrs", {48'd0, bus0.bram_rd_addr, bus0.bram_wr_addr}, 64'd0);
    checkOutput("rst_data", bus0.bram_wr_data, 64'd0);
    checkOutput("rst_qa", {44'd0, bus0.qa_A, bus0.qa_R}, 64'd0);
    checkOutput("rst_done", 64'(bus0.done), 64'd0);
    checkOutput("rst_step", 64'(bus0.step_cnt), 64'd0);

    $display("[TB] single update");
    runSingle(8'd5, 8'd9, 4'd6, 16'hFFFD, 16'h0123, 1);

    $display("[TB] same state update");
    runSingle(8'd17, 8'd17, 4'd15, 16'd100, 16'hBEEF, 2);

    $display("[TB] reset in PIPE");
    @(negedge clk);
    applyStimulus(1'b1, 8'd50, 8'd51, 4'd2, 16'd7);
    waitReady("rst_accept_wait");
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 8'd0, 4'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pipe_wr_en", 64'(bus0.bram_wr_en), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_low_wr_en", 64'(bus0.bram_wr_en), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_rel_ready", 64'(bus0.req_ready), 64'd1);
    checkOutput("rst_rel_step", 64'(bus0.step_cnt), 64'd0);
    for (int k = 0; k < 10; k++) begin
      checkOutput("rst_no_write", 64'(bus0.bram_wr_en), 64'd0);
      @(negedge clk);
    end

    $display("[TB] back-to-back requests");
    bs  = '{8'd20, 8'd30, 8'd40};
    bsn = '{8'd21, 8'd31, 8'd41};
    ba  = '{4'd0, 4'd5, 4'd10};
    br  = '{16'd1, 16'd2, 16'd3};
    acc_t = '{0, 0, 0};
    n_acc = 0;
    n_wr  = 0;
    pend  = 1'b0;
    applyStimulus(1'b1, bs[0], bsn[0], ba[0], br[0]);
    for (int c = 0; c < 40; c++) begin
      if (pend) begin
        pend = 1'b0;
        if (n_acc < 3) applyStimulus(1'b1, bs[n_acc], bsn[n_acc], ba[n_acc], br[n_acc]);
        else           applyStimulus(1'b0, 8'd0, 8'd0, 4'd0, 16'd0);
      end
      checkOutput("b2b_overlap", 64'(bus0.bram_rd_en && (bus0.bram_wr_en != 4'd0)), 64'd0);
      if (bus0.bram_wr_en != 4'd0) begin
        if (n_wr < 3) checkOutput("b2b_wr_addr", 64'(bus0.bram_wr_addr), 64'(bs[n_wr]));
        n_wr++;
      end
      if (bus0.req_valid && bus0.req_ready) begin
        if (n_acc < 3) acc_t[n_acc] = c;
        n_acc++;
        pend = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput("b2b_accepts", 64'(n_acc), 64'd3);
    checkOutput("b2b_writes", 64'(n_wr), 64'd3);
    checkOutput("b2b_gap01", 64'(acc_t[1] - acc_t[0]), 64'd8);
    checkOutput("b2b_gap12", 64'(acc_t[2] - acc_t[1]), 64'd8);
    checkOutput("b2b_step", 64'(bus0.step_cnt), 64'd3);

    $display("[TB] long latency instance");
    bus1.req_valid  = 1'b1;
    bus1.req_S      = 8'd3;
    bus1.req_S_next = 8'd4;
    bus1.req_A      = 4'd9;
    bus1.req_R      = 16'd11;
    checkOutput("sweep_ready", 64'(bus1.req_ready), 64'd1);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    j = 0;
    while (bus1.bram_wr_en == 4'd0 && j < 40) begin
      @(negedge clk);
      j++;
    end
    checkOutput("sweep_write_cycle", 64'(j), 64'(2 + P1));
    checkOutput("sweep_wr_en", 64'(bus1.bram_wr_en), 64'b0010);
    checkOutput("sweep_lane", 64'(bus1.bram_wr_lane), 64'b0100);
    checkOutput("sweep_data", bus1.bram_wr_data, {4{16'h7777}});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
